// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL lock qualifier and SDRAM power-up reset sequencer
// Optional feature macro: PLL_RST_SEQ_LOSS_CNT_EN (adds lock_loss_cnt[7:0])
module pll_rst_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SYS_RST_HOLD       = 16,
  parameter int PWRUP_CYCLES       = 21000,
  parameter int CNT_W              = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       init_done,
  output logic       sys_rst_n,
  output logic       sdram_rst_n,
  output logic       init_req,
  output logic       ready
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_STABLE,
    S_SYS_HOLD,
    S_PWRUP,
    S_INIT_REQ,
    S_WAIT_DONE,
    S_READY
  } state_t;

  // Terminal counts; each timed state leaves when cnt reaches its last value.
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SYS_RST_HOLD - 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_t                 state_q, state_nx;
  logic [CNT_W-1:0]       cnt_q, cnt_nx;
  logic                   sys_nx, sdram_nx, init_req_nx, ready_nx;

  // Synchronise the asynchronous lock input into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // State, shared counter and registered output decodes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_WAIT_LOCK;
      cnt_q       <= '0;
      sys_rst_n   <= 1'b0;
      sdram_rst_n <= 1'b0;
      init_req    <= 1'b0;
      ready       <= 1'b0;
    end else begin
      state_q     <= state_nx;
      cnt_q       <= cnt_nx;
      sys_rst_n   <= sys_nx;
      sdram_rst_n <= sdram_nx;
      init_req    <= init_req_nx;
      ready       <= ready_nx;
    end
  end

  // Next state and counter; outputs decode the next state so they move with it.
  always_comb begin
    state_nx    = state_q;
    cnt_nx      = cnt_q;
    sys_nx      = 1'b0;
    sdram_nx    = 1'b0;
    init_req_nx = 1'b0;
    ready_nx    = 1'b0;

    case (state_q)
      S_WAIT_LOCK: begin
        if (lock_s) state_nx = S_STABLE;
      end
      S_STABLE: begin
        if (cnt_q == LOCK_LAST) state_nx = S_SYS_HOLD;
        else                    cnt_nx   = cnt_q + 1'b1;
      end
      S_SYS_HOLD: begin
        if (cnt_q == HOLD_LAST) state_nx = S_PWRUP;
        else                    cnt_nx   = cnt_q + 1'b1;
      end
      S_PWRUP: begin
        if (cnt_q == PWRUP_LAST) state_nx = S_INIT_REQ;
        else                     cnt_nx   = cnt_q + 1'b1;
      end
      S_INIT_REQ: begin
        state_nx = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (init_done) state_nx = S_READY;
      end
      S_READY: begin
        state_nx = S_READY;
      end
      default: begin
        state_nx = S_WAIT_LOCK;
      end
    endcase

    // Losing lock beats any other transition, including a count completing now.
    if (state_q != S_WAIT_LOCK && !lock_s) begin
      state_nx = S_WAIT_LOCK;
    end

    if (state_nx != state_q) begin
      cnt_nx = '0;
    end

    case (state_nx)
      S_SYS_HOLD: begin
        sys_nx = 1'b1;
      end
      S_PWRUP, S_WAIT_DONE: begin
        sys_nx   = 1'b1;
        sdram_nx = 1'b1;
      end
      S_INIT_REQ: begin
        sys_nx      = 1'b1;
        sdram_nx    = 1'b1;
        init_req_nx = 1'b1;
      end
      S_READY: begin
        sys_nx   = 1'b1;
        sdram_nx = 1'b1;
        ready_nx = 1'b1;
      end
      default: begin
        sys_nx = 1'b0;
      end
    endcase
  end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic loss_evt;

  assign loss_evt = (state_q != S_WAIT_LOCK) && !lock_s;

  // Saturating count of lock-loss restarts; only rst_n clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_loss_cnt <= 8'd0;
    end else if (loss_evt && lock_loss_cnt != 8'hFF) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb/tb_pll_rst_seq.sv - randomized self-checking bench for pll_rst_seq
module tb_pll_rst_seq;

  localparam int S = 2;
  localparam int L = 8;
  localparam int H = 4;
  localparam int P = 10;
  localparam int W = L + H + P + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_lock = 1'b0;
  logic init_done = 1'b0;
  logic sys_rst_n, sdram_rst_n, init_req, ready;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pll_rst_seq #(
    .SYNC_STAGES(S), .LOCK_STABLE_CYCLES(L), .SYS_RST_HOLD(H),
    .PWRUP_CYCLES(P), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .init_done(init_done),
    .sys_rst_n(sys_rst_n), .sdram_rst_n(sdram_rst_n),
    .init_req(init_req), .ready(ready)
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    , .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Timeline model: m_t counts edges since lock was qualified-start.
  logic [S-1:0] m_sync = '0;
  bit m_active = 0;
  int m_t = 0;
  bit m_rdy = 0;
  int m_loss = 0;

  always @(posedge clk) begin : model
    logic ls;
    if (!rst_n) begin
      m_sync = '0; m_active = 0; m_t = 0; m_rdy = 0; m_loss = 0;
    end else begin
      ls = m_sync[S-1];
      m_sync = {m_sync[S-2:0], pll_lock};
      if (!m_active) begin
        if (ls) begin m_active = 1; m_t = 0; m_rdy = 0; end
      end else if (!ls) begin
        m_active = 0; m_t = 0; m_rdy = 0;
        if (m_loss < 255) m_loss++;
      end else if (m_t < W) begin
        m_t++;
      end else if (init_done) begin
        m_rdy = 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and compare every output against the model.
  task automatic cyc();
    @(negedge clk);
    check("sys_rst_n", 32'(sys_rst_n), 32'(m_active && m_t >= L));
    check("sdram_rst_n", 32'(sdram_rst_n), 32'(m_active && m_t >= L + H));
    check("init_req", 32'(init_req), 32'(m_active && m_t == L + H + P));
    check("ready", 32'(ready), 32'(m_active && m_rdy));
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Nominal sequence from WAIT_LOCK with absolute edge expectations.
  task automatic nominal();
    init_done = 1'b0;
    pll_lock = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      cyc();
      if (k == 10) check("nom_sys_pre", 32'(sys_rst_n), 0);
      if (k == 11) check("nom_sys", 32'(sys_rst_n), 1);
      if (k == 14) check("nom_sdram_pre", 32'(sdram_rst_n), 0);
      if (k == 15) check("nom_sdram", 32'(sdram_rst_n), 1);
      if (k == 24) check("nom_ireq_pre", 32'(init_req), 0);
      if (k == 25) check("nom_ireq", 32'(init_req), 1);
      if (k == 26) check("nom_ireq_post", 32'(init_req), 0);
      if (k == 30) begin
        check("nom_ready_pre", 32'(ready), 0);
        init_done = 1'b1;
      end
      if (k == 31) check("nom_ready", 32'(ready), 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle(3);
    check("rst_sys", 32'(sys_rst_n), 0);
    check("rst_sdram", 32'(sdram_rst_n), 0);
    check("rst_ireq", 32'(init_req), 0);
    check("rst_ready", 32'(ready), 0);
    rst_n = 1'b1;
    idle(4);

    nominal();

    // Lock loss in READY, then relock with nominal timing.
    pll_lock = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (k == 2) check("loss_ready_hold", 32'(ready), 1);
      if (k == 3) begin
        check("loss_ready", 32'(ready), 0);
        check("loss_sdram", 32'(sdram_rst_n), 0);
        check("loss_sys", 32'(sys_rst_n), 0);
      end
    end
    idle(3);
    nominal();

    // One-cycle glitch five cycles into qualification.
    pll_lock = 1'b0;
    init_done = 1'b0;
    idle(5);
    pll_lock = 1'b1;
    idle(8);
    pll_lock = 1'b0;
    cyc();
    pll_lock = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      cyc();
      if (j <= 10) check("glitch_sys_low", 32'(sys_rst_n), 0);
      if (j == 11) check("glitch_sys", 32'(sys_rst_n), 1);
      if (j == 20) begin
        // Now inside PWRUP: reset for one edge.
        rst_n = 1'b0;
        cyc();
        check("mid_rst_sys", 32'(sys_rst_n), 0);
        check("mid_rst_sdram", 32'(sdram_rst_n), 0);
        check("mid_rst_ireq", 32'(init_req), 0);
        check("mid_rst_ready", 32'(ready), 0);
        rst_n = 1'b1;
      end
    end
    for (int j = 1; j <= 11; j++) begin
      cyc();
      if (j == 10) check("after_rst_sys_pre", 32'(sys_rst_n), 0);
      if (j == 11) check("after_rst_sys", 32'(sys_rst_n), 1);
    end

    // init_done held high early: ignored until WAIT_DONE.
    pll_lock = 1'b0;
    idle(4);
    init_done = 1'b1;
    pll_lock = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      cyc();
      if (k == 24) check("early_done_ready_pre", 32'(ready), 0);
      if (k == 25) check("early_done_ireq", 32'(init_req), 1);
      if (k == 26) check("early_done_ready_mid", 32'(ready), 0);
      if (k == 27) check("early_done_ready", 32'(ready), 1);
    end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    rst_n = 1'b0;
    pll_lock = 1'b0;
    init_done = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pll_lock = 1'b1; idle(15);
      pll_lock = 1'b0; idle(4);
    end
    check("loss_cnt_3", 32'(lock_loss_cnt), 3);
    for (int i = 0; i < 6; i++) begin
      init_done = ~init_done; cyc();
    end
    check("loss_cnt_waitlock", 32'(lock_loss_cnt), 3);
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1; idle(4);
      pll_lock = 1'b0; idle(3);
    end
    check("loss_cnt_sat", 32'(lock_loss_cnt), 255);
    idle(5);
    check("loss_cnt_sat_idle", 32'(lock_loss_cnt), 255);
`endif

    // Randomized segments.
    for (int seg = 0; seg < 60; seg++) begin
      int mode;
      int len;
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        rst_n = 1'b0;
        idle($urandom_range(1, 2));
        rst_n = 1'b1;
      end else if (mode <= 3) begin
        pll_lock = 1'b0;
        idle($urandom_range(1, 3));
        pll_lock = 1'b1;
      end else begin
        pll_lock = 1'b1;
        len = $urandom_range(20, 50);
        for (int i = 0; i < len; i++) begin
          init_done = ($urandom_range(0, 3) == 0);
          cyc();
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
